vga_text_controller: RTL and testbench
======================================

VGA_TEXT_CONTROLLER -- requirements
Module: vga_text_controller

Interface
REQ-001 SHALL have parameters, one per line:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, hsync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vsync width.
- V_BP, 33, vertical back porch.
- HS_POL, 0, active level of hsync.
- VS_POL, 0, active level of vsync.
- GLYPH_W, 8, glyph width in pixels.
- GLYPH_H, 16, glyph height in lines.
- COLS, H_ACTIVE/GLYPH_W, text columns.
- ROWS, V_ACTIVE/GLYPH_H, text rows.
- BLINK_FRAMES, 30, frames per cursor blink phase.
- AW, clog2(COLS*ROWS), VRAM address width.
REQ-002 SHALL have ports, one per line:
- clk_i, in, 1, pixel clock; one clock domain; reset is synchronous and active-high.
- reset_i, in, 1, synchronous active-high reset.
- vram_addr_o, out, AW, text cell address.
- vram_data_i, in, 16, {attr[7:0], char[7:0]}; valid 1 cycle after address.
- crom_addr_o, out, 8+clog2(GLYPH_H), {char, glyph_row}.
- crom_data_i, in, GLYPH_W, glyph row bits, MSB = leftmost pixel; valid 1 cycle after address.
- pal_we_i, in, 1, palette write strobe.
- pal_addr_i, in, 4, palette index.
- pal_data_i, in, 12, {r,g,b} nibbles.
- cursor_en_i, in, 1, cursor enable.
- cursor_col_i, in, 8, cursor column.
- cursor_row_i, in, 8, cursor row.
- vga_red_o, out, 4, red.
- vga_green_o, out, 4, green.
- vga_blue_o, out, 4, blue.
- vga_hsync_o, out, 1, hsync.
- vga_vsync_o, out, 1, vsync.
- vblank_o, out, 1, high while the output line is >= V_ACTIVE.
- frame_start_o, out, 1, one-cycle pulse when output pixel (0,0) is driven.

Function
REQ-003 Counters: x counts 0..H_TOTAL-1 (H_TOTAL = sum of H params), then wraps to 0; y increments on each x wrap and wraps from V_TOTAL-1 to 0.
REQ-004 Fetch stage SHALL run 3 cycles ahead of output; vram_addr_o = row*COLS + col for the lead coordinate.
REQ-005 The row base SHALL be an accumulator (+COLS per GLYPH_H lines, cleared at frame wrap); no multiplier.
REQ-006 crom_addr_o = {vram_data_i[7:0], lead glyph_row} registered-aligned so crom_data_i arrives in the cycle before output register load.
REQ-007 Pixel bit = crom_data_i[GLYPH_W-1 - glyph_col]; fg = attr[3:0], bg = attr[7:4]; colour = palette[bit ? fg : bg].
REQ-008 Cursor SHALL invert the cell: fg/bg swapped when cursor_en_i=1, the cell matches (cursor_col_i, cursor_row_i), and blink phase = 1.
REQ-009 Blink phase SHALL toggle every BLINK_FRAMES frame wraps; it is reset to 1.
REQ-010 Outside the active area, RGB = 0 regardless of VRAM/CROM data.
REQ-011 hsync SHALL be HS_POL when H_ACTIVE+H_FP <= x_out < H_ACTIVE+H_FP+H_SYNC, else !HS_POL; vsync is analogous with V params and VS_POL.
REQ-012 RGB, syncs, vblank_o and frame_start_o SHALL be registered and mutually aligned to the same output coordinate.
REQ-013 Palette writes SHALL take effect on pixels registered 2+ cycles after the write; a same-cycle read gets the old value.
REQ-014 Cursor inputs SHALL be sampled once per cell fetch; changes mid-cell apply from the next cell.

Reset
REQ-015 During reset and the first cycle after it: RGB=0, hsync=!HS_POL, vsync=!VS_POL, vblank_o=0, frame_start_o=0, counters=0, row base=0.
REQ-016 Palette entry i SHALL reset to {i,i,i}.
REQ-017 Reset asserted mid-line SHALL restart the frame from (0,0) with no partial sync pulse emitted.

Verification
REQ-018 Default params, free run -> hsync low for exactly 96 cycles per 800-cycle line; vsync low for 2 lines of 525; frame_start_o period = 420000 cycles.
REQ-019 VRAM cell 81 = 0x1F41, crom row = 0x80, palette[1]=0x00F, palette[15]=0xFFF -> output pixel (8,16) = 0xFFF and (9,16) = 0x00F.
REQ-020 Cursor at (0,0), BLINK_FRAMES=2 -> cell 0 colours swap for frames 0-1, normal for frames 2-3, swapped for 4-5.
REQ-021 pal_we_i writes 0xF00 to index 0 mid-line -> subsequent background pixels are red from write+2 cycles.
REQ-022 Reset at x=700,y=100 -> syncs inactive during reset; next frame_start_o occurs 3 cycles after release.
REQ-023 Params GLYPH_W=6, GLYPH_H=8, COLS=106 -> vram_addr_o for pixel (12,8) = 108.

Source files
------------

// File: rtl/vga_text_controller.sv
// rtl/vga_text_controller.sv - 80x30-style text-mode VGA generator.
// Fetch runs three pixels ahead of the registered output: VRAM, then CROM, then palette.
module vga_text_controller #(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b0,
  parameter int   GLYPH_W      = 8,
  parameter int   GLYPH_H      = 16,
  parameter int   COLS         = H_ACTIVE / GLYPH_W,
  parameter int   ROWS         = V_ACTIVE / GLYPH_H,
  parameter int   BLINK_FRAMES = 30,
  parameter int   AW           = $clog2(COLS * ROWS)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  output logic [AW-1:0]                 vram_addr_o,
  input  logic [15:0]                   vram_data_i,
  output logic [8+$clog2(GLYPH_H)-1:0]  crom_addr_o,
  input  logic [GLYPH_W-1:0]            crom_data_i,
  input  logic                          pal_we_i,
  input  logic [3:0]                    pal_addr_i,
  input  logic [11:0]                   pal_data_i,
  input  logic                          cursor_en_i,
  input  logic [7:0]                    cursor_col_i,
  input  logic [7:0]                    cursor_row_i,
  output logic [3:0]                    vga_red_o,
  output logic [3:0]                    vga_green_o,
  output logic [3:0]                    vga_blue_o,
  output logic                          vga_hsync_o,
  output logic                          vga_vsync_o,
  output logic                          vblank_o,
  output logic                          frame_start_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int GCW     = $clog2(GLYPH_W);
  localparam int GRW     = $clog2(GLYPH_H);
  localparam int BW      = $clog2(BLINK_FRAMES + 1);

  typedef struct packed {
    logic           act;
    logic           hs;
    logic           vs;
    logic           vb;
    logic           fs;
    logic           hit;
    logic [GCW-1:0] gcol;
  } stage_t;

  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [GCW-1:0] gcol_q, gcol_d;
  logic [GRW-1:0] grow_q, grow_d, grow1_q, grow1_d;
  logic [7:0]     col_q, col_d, row_q, row_d;
  logic [AW-1:0]  row_base_q, row_base_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           blink_q, blink_d;
  logic           hit_q, hit_d;
  stage_t         s1_q, s1_d, s2_q, s2_d;
  logic [7:0]     attr2_q, attr2_d;
  logic [11:0]    pal_q [16];
  logic [11:0]    pal_d [16];
  logic [11:0]    rgb_q, rgb_d;
  logic           hs_q, hs_d, vs_q, vs_d, vb_q, vb_d, fs_q, fs_d;
  logic           x_wrap, y_wrap, gcol_wrap, grow_wrap, pix_bit;
  logic [3:0]     fg, bg;

  always_comb begin
    x_wrap    = (x_q == XW'(H_TOTAL - 1));
    y_wrap    = (y_q == YW'(V_TOTAL - 1));
    gcol_wrap = (gcol_q == GCW'(GLYPH_W - 1));
    grow_wrap = (grow_q == GRW'(GLYPH_H - 1));

    x_d         = x_wrap ? '0 : x_q + 1'b1;
    gcol_d      = (x_wrap || gcol_wrap) ? '0 : gcol_q + 1'b1;
    col_d       = x_wrap ? '0 : (gcol_wrap ? col_q + 8'd1 : col_q);
    y_d         = y_q;
    grow_d      = grow_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (x_wrap) begin
      if (y_wrap) begin
        y_d        = '0;
        grow_d     = '0;
        row_d      = '0;
        row_base_d = '0;
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        y_d = y_q + 1'b1;
        if (grow_wrap) begin
          grow_d     = '0;
          row_d      = row_q + 8'd1;
          row_base_d = row_base_q + AW'(COLS);
        end else begin
          grow_d = grow_q + 1'b1;
        end
      end
    end

    // Cursor match is decided on the first pixel of a cell and held for the rest of it
    hit_d = (gcol_q == '0) ? (cursor_en_i && blink_q && (col_q == cursor_col_i) && (row_q == cursor_row_i))
                           : hit_q;

    s1_d.act  = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
    s1_d.hs   = ((x_q >= XW'(H_ACTIVE + H_FP)) && (x_q < XW'(H_ACTIVE + H_FP + H_SYNC))) ? HS_POL : ~HS_POL;
    s1_d.vs   = ((y_q >= YW'(V_ACTIVE + V_FP)) && (y_q < YW'(V_ACTIVE + V_FP + V_SYNC))) ? VS_POL : ~VS_POL;
    s1_d.vb   = (y_q >= YW'(V_ACTIVE));
    s1_d.fs   = (x_q == '0) && (y_q == '0);
    s1_d.hit  = hit_d;
    s1_d.gcol = gcol_q;
    grow1_d   = grow_q;

    s2_d    = s1_q;
    attr2_d = vram_data_i[15:8];

    pix_bit = crom_data_i[GCW'(GLYPH_W - 1) - s2_q.gcol];
    fg      = s2_q.hit ? attr2_q[7:4] : attr2_q[3:0];
    bg      = s2_q.hit ? attr2_q[3:0] : attr2_q[7:4];
    rgb_d   = s2_q.act ? pal_q[pix_bit ? fg : bg] : 12'h000;
    hs_d    = s2_q.hs;
    vs_d    = s2_q.vs;
    vb_d    = s2_q.vb;
    fs_d    = s2_q.fs;

    pal_d = pal_q;
    if (pal_we_i) pal_d[pal_addr_i] = pal_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q         <= '0;
      y_q         <= '0;
      gcol_q      <= '0;
      grow_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      hit_q       <= 1'b0;
      s1_q        <= '0;
      s1_q.hs     <= ~HS_POL;
      s1_q.vs     <= ~VS_POL;
      s2_q        <= '0;
      s2_q.hs     <= ~HS_POL;
      s2_q.vs     <= ~VS_POL;
      grow1_q     <= '0;
      attr2_q     <= '0;
      for (int i = 0; i < 16; i++) pal_q[i] <= {3{4'(i)}};
      rgb_q       <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      vb_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      gcol_q      <= gcol_d;
      grow_q      <= grow_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      hit_q       <= hit_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      grow1_q     <= grow1_d;
      attr2_q     <= attr2_d;
      pal_q       <= pal_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vb_q        <= vb_d;
      fs_q        <= fs_d;
    end
  end

  assign vram_addr_o   = row_base_q + AW'(col_q);
  assign crom_addr_o   = {vram_data_i[7:0], grow1_q};
  assign vga_red_o     = rgb_q[11:8];
  assign vga_green_o   = rgb_q[7:4];
  assign vga_blue_o    = rgb_q[3:0];
  assign vga_hsync_o   = hs_q;
  assign vga_vsync_o   = vs_q;
  assign vblank_o      = vb_q;
  assign frame_start_o = fs_q;
endmodule

// File: tb/tb_vga_text_controller.sv
// tb/tb_vga_text_controller.sv - directed checks of vga_text_controller.
// Three instances: default timing, a tiny frame for blink/vsync/reset, and 6x8 glyphs for addressing.
module tb_vga_text_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int t     = 0;
  int hs_lo = 0, hs_first = -1, vs_lo = 0, vb_n = 0;

  // default-timing instance
  logic        rst_m;
  logic [11:0] m_vaddr, m_caddr;
  logic [15:0] m_vdata;
  logic [7:0]  m_cdata;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic [3:0]  m_r, m_g, m_b;
  logic        m_hs, m_vs, m_vb, m_fs;

  vga_text_controller u_dut (
    .clk_i(clk), .reset_i(rst_m), .vram_addr_o(m_vaddr), .vram_data_i(m_vdata),
    .crom_addr_o(m_caddr), .crom_data_i(m_cdata), .pal_we_i(pal_we), .pal_addr_i(pal_addr),
    .pal_data_i(pal_data), .cursor_en_i(1'b0), .cursor_col_i(8'd0), .cursor_row_i(8'd0),
    .vga_red_o(m_r), .vga_green_o(m_g), .vga_blue_o(m_b), .vga_hsync_o(m_hs),
    .vga_vsync_o(m_vs), .vblank_o(m_vb), .frame_start_o(m_fs)
  );

  always @(posedge clk) begin
    m_vdata <= (m_vaddr == 12'd81) ? 16'h1F41 : 16'h0300;
    m_cdata <= (m_caddr == 12'h410) ? 8'h80 : 8'h3C;
  end

  // small-frame instance: 48x38 total, 4x2 cells, cursor at (0,0), blink every 2 frames
  logic        rst_s;
  logic [2:0]  s_vaddr;
  logic [11:0] s_caddr;
  logic [7:0]  s_cur_col;
  logic [3:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs, s_vb, s_fs;

  vga_text_controller #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2), .BLINK_FRAMES(2)
  ) u_small (
    .clk_i(clk), .reset_i(rst_s), .vram_addr_o(s_vaddr), .vram_data_i(16'h1200),
    .crom_addr_o(s_caddr), .crom_data_i(8'h80), .pal_we_i(1'b0), .pal_addr_i(4'd0),
    .pal_data_i(12'h000), .cursor_en_i(1'b1), .cursor_col_i(s_cur_col), .cursor_row_i(8'd0),
    .vga_red_o(s_r), .vga_green_o(s_g), .vga_blue_o(s_b), .vga_hsync_o(s_hs),
    .vga_vsync_o(s_vs), .vblank_o(s_vb), .frame_start_o(s_fs)
  );

  // 6x8 glyph instance, COLS = 106
  logic        rst_g;
  logic [12:0] g_vaddr;
  logic [10:0] g_caddr;
  logic [3:0]  g_r, g_g, g_b;
  logic        g_hs, g_vs, g_vb, g_fs;

  vga_text_controller #(.GLYPH_W(6), .GLYPH_H(8)) u_g6 (
    .clk_i(clk), .reset_i(rst_g), .vram_addr_o(g_vaddr), .vram_data_i(16'h0000),
    .crom_addr_o(g_caddr), .crom_data_i(6'h00), .pal_we_i(1'b0), .pal_addr_i(4'd0),
    .pal_data_i(12'h000), .cursor_en_i(1'b0), .cursor_col_i(8'd0), .cursor_row_i(8'd0),
    .vga_red_o(g_r), .vga_green_o(g_g), .vga_blue_o(g_b), .vga_hsync_o(g_hs),
    .vga_vsync_o(g_vs), .vblank_o(g_vb), .frame_start_o(g_fs)
  );

  wire [11:0] m_rgb = {m_r, m_g, m_b};
  wire [11:0] s_rgb = {s_r, s_g, s_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // t counts clock edges since the shared reset release; output pixel n is visible at t = n + 3
  task automatic tick_to(input int target);
    while (t < target) begin
      @(negedge clk);
      t++;
      if (t >= 3 && t <= 802 && m_hs == 1'b0) begin
        hs_lo++;
        if (hs_first < 0) hs_first = t - 3;
      end
      if (t >= 1827 && t <= 3650) begin
        if (s_vs == 1'b0) vs_lo++;
        if (s_vb == 1'b1) vb_n++;
      end
    end
  endtask

  initial begin
    rst_m = 1'b1; rst_s = 1'b1; rst_g = 1'b1;
    pal_we = 1'b0; pal_addr = 4'd0; pal_data = 12'h000; s_cur_col = 8'd0;
    repeat (4) @(negedge clk);
    chk("rst_rgb", m_rgb, 12'h000);
    chk("rst_hsync", m_hs, 1'b1);
    chk("rst_vsync", m_vs, 1'b1);
    chk("rst_vblank", m_vb, 1'b0);
    chk("rst_frame_start", m_fs, 1'b0);

    rst_m = 1'b0; rst_s = 1'b0; rst_g = 1'b0;
    chk("c0_rgb", m_rgb, 12'h000);
    chk("c0_hsync", m_hs, 1'b1);
    chk("c0_vram_addr", m_vaddr, 12'd0);
    chk("g6_vram_addr_0", g_vaddr, 13'd0);
    pal_we = 1'b1; pal_addr = 4'd1; pal_data = 12'h00F;
    tick_to(1); pal_we = 1'b0;
    tick_to(2); chk("fs_before", m_fs, 1'b0); chk("hsync_fill", m_hs, 1'b1);
    tick_to(3); chk("fs_first", m_fs, 1'b1); chk("small_fs_first", s_fs, 1'b1);
    chk("cursor_f0", s_rgb, 12'h111);
    tick_to(4); chk("fs_pulse_end", m_fs, 1'b0);
    tick_to(5); chk("pix_2_0_fg", m_rgb, 12'h333);
    tick_to(11); chk("cell1_no_cursor", s_rgb, 12'h222);
    tick_to(703); chk("blank_x700", m_rgb, 12'h000); chk("vblank_line0", m_vb, 1'b0);
    tick_to(803); chk("hsync_low_cycles", hs_lo, 96); chk("hsync_first_x", hs_first, 656);

    tick_to(906); pal_we = 1'b1; pal_addr = 4'd0; pal_data = 12'hF00;
    tick_to(907); pal_we = 1'b0; chk("pal_old_value", m_rgb, 12'h000);
    tick_to(908); chk("pal_new_value", m_rgb, 12'hF00);
    tick_to(909); chk("pal_fg_unchanged", m_rgb, 12'h333);

    tick_to(1826); chk("small_fs_gap", s_fs, 1'b0);
    tick_to(1827); chk("small_fs_period", s_fs, 1'b1); chk("cursor_f1", s_rgb, 12'h111);
    tick_to(3651); chk("vsync_low_cycles", vs_lo, 96); chk("vblank_cycles", vb_n, 288);
    chk("cursor_f2", s_rgb, 12'h222);
    tick_to(5475); chk("cursor_f3", s_rgb, 12'h222);
    tick_to(6411); chk("g6_addr_11_8", g_vaddr, 13'd107);
    tick_to(6412); chk("g6_addr_12_8", g_vaddr, 13'd108);
    tick_to(7299); chk("cursor_f4", s_rgb, 12'h111);
    tick_to(9123); chk("cursor_f5", s_rgb, 12'h111);
    s_cur_col = 8'd1;
    tick_to(9128); chk("cursor_held_in_cell", s_rgb, 12'h222);
    tick_to(9131); chk("cursor_next_cell", s_rgb, 12'h111);
    tick_to(9171); chk("cursor_moved_away", s_rgb, 12'h222);

    tick_to(9304); chk("small_hsync_active", s_hs, 1'b0);
    rst_s = 1'b1;
    tick_to(9305); chk("mid_rst_hsync", s_hs, 1'b1); chk("mid_rst_vsync", s_vs, 1'b1);
    chk("mid_rst_rgb", s_rgb, 12'h000); chk("mid_rst_fs", s_fs, 1'b0);
    tick_to(9306); rst_s = 1'b0; chk("rel_hsync", s_hs, 1'b1);
    tick_to(9308); chk("rel_fs_early", s_fs, 1'b0); chk("rel_hsync_fill", s_hs, 1'b1);
    tick_to(9309); chk("rel_fs_3_cycles", s_fs, 1'b1);

    tick_to(12808); chk("vram_addr_cell81", m_vaddr, 12'd81);
    tick_to(12809); chk("crom_addr_row0", m_caddr, 12'h410);
    tick_to(12810); chk("pix_7_16_bg", m_rgb, 12'hF00);
    tick_to(12811); chk("pix_8_16", m_rgb, 12'hFFF);
    tick_to(12812); chk("pix_9_16", m_rgb, 12'h00F);
    tick_to(12813); chk("pix_10_16", m_rgb, 12'h00F);
    tick_to(13609); chk("crom_addr_row1", m_caddr, 12'h411);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
